// File: rtl/npc_fetch_if.sv
// npc_fetch_if: bundles the F-stage next-PC controls and the fetch outputs.
//  master : the D-stage/CP0 side. It drives the redirect controls and reads the fetch outputs.
//  slave  : npc_fetch. It reads the controls and drives pc_f/bd_f/adel_f/flush_fd.
//  Signals:
//   stall, is_branch, cmp_true, is_j, is_jr, eret, exc_req : 1-bit controls
//   imm16 (16), instr_index (26), rs_val (32), pc_d (32), epc (32) : redirect operands
//   pc_f (32), bd_f, adel_f, flush_fd : fetch-side results
interface npc_fetch_if;
  logic        stall;
  logic        is_branch;
  logic        cmp_true;
  logic        is_j;
  logic        is_jr;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic [31:0] pc_d;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic        bd_f;
  logic        adel_f;
  logic        flush_fd;

  modport master (
    output stall, is_branch, cmp_true, is_j, is_jr, imm16, instr_index,
           rs_val, pc_d, exc_req, eret, epc,
    input  pc_f, bd_f, adel_f, flush_fd
  );

  modport slave (
    input  stall, is_branch, cmp_true, is_j, is_jr, imm16, instr_index,
           rs_val, pc_d, exc_req, eret, epc,
    output pc_f, bd_f, adel_f, flush_fd
  );
endinterface

// File: rtl/npc_fetch.sv
// npc_fetch: PC register and next-PC selector for the F stage of a 5-stage MIPS pipeline.
//  clk   : rising-edge clock
//  reset : synchronous, active-high; loads RESET_PC
//  bus   : npc_fetch_if.slave
//          inputs  : stall, D-stage branch/jump decode and operands, CP0 exc_req/eret/epc
//          outputs : pc_f (registered fetch address), bd_f (delay-slot flag),
//                    adel_f (fetch address error), flush_fd (clear F/D after eret)
//  Redirect priority, highest first:
//    reset > exc_req > stall > eret > jr > j > taken branch > sequential.
module npc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  npc_fetch_if.slave  bus
);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pc_seq_s;
  logic [31:0] pc_d_plus4_s;
  logic [31:0] br_off_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;

  // Fetch address error: misaligned word or outside the text window (unsigned compare).
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < TEXT_LO) || (a > TEXT_HI);
  endfunction

  // Redirect targets. All adds wrap silently at 32 bits; adel_f reports a wrapped address.
  assign pc_seq_s     = pc_r + 32'd4;
  assign pc_d_plus4_s = bus.pc_d + 32'd4;
  assign br_off_s     = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign br_target_s  = pc_d_plus4_s + br_off_s;
  assign j_target_s   = {pc_d_plus4_s[31:28], bus.instr_index, 2'b00};

  // Next-PC priority mux. A stall holds the PC, so a stalled D instr redirects
  // only once it is re-evaluated in its first unstalled cycle.
  always_comb begin
    pc_next_s = pc_seq_s;
    if (bus.exc_req) begin
      pc_next_s = EXC_ENTRY;
    end else if (bus.stall) begin
      pc_next_s = pc_r;
    end else if (bus.eret) begin
      pc_next_s = bus.epc;
    end else if (bus.is_jr) begin
      pc_next_s = bus.rs_val;
    end else if (bus.is_j) begin
      pc_next_s = j_target_s;
    end else if (bus.is_branch && bus.cmp_true) begin
      pc_next_s = br_target_s;
    end else begin
      pc_next_s = pc_seq_s;
    end
  end

  // PC register; reset overrides every pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign bus.pc_f     = pc_r;
  assign bus.adel_f   = addr_err(pc_r);
  // The instruction after any branch/jump is a delay slot, taken or not, and
  // the flag stays up while the D instr is held by a stall.
  assign bus.bd_f     = (bus.is_branch | bus.is_j | bus.is_jr) & ~bus.exc_req & ~reset;
  // eret has no delay slot: the instruction fetched behind it is squashed.
  assign bus.flush_fd = bus.eret & ~bus.stall & ~bus.exc_req & ~reset;

endmodule

// File: tb/tb_npc_fetch.sv
module tb_npc_fetch;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [31:0] m_pc;
  bit          m_valid;

  npc_fetch_if bus();

  npc_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, written straight from the architectural behaviour.
  function automatic logic [31:0] ref_next(input logic [31:0] pc);
    logic [31:0] base;
    logic [31:0] sext;
    base = bus.pc_d + 32'd4;
    sext = {{16{bus.imm16[15]}}, bus.imm16} * 32'd4;
    if (reset)                           return 32'h0000_3000;
    if (bus.exc_req)                     return 32'h0000_4180;
    if (bus.stall)                       return pc;
    if (bus.eret)                        return bus.epc;
    if (bus.is_jr)                       return bus.rs_val;
    if (bus.is_j)                        return (base & 32'hF000_0000) | ({6'd0, bus.instr_index} * 32'd4);
    if (bus.is_branch && bus.cmp_true)   return base + sext;
    return pc + 32'd4;
  endfunction

  function automatic logic ref_adel(input logic [31:0] pc);
    return (pc % 32'd4 != 32'd0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6ffc);
  endfunction

  task automatic clear_ctrl();
    bus.stall = 1'b0; bus.is_branch = 1'b0; bus.cmp_true = 1'b0;
    bus.is_j = 1'b0; bus.is_jr = 1'b0; bus.imm16 = 16'h0000;
    bus.instr_index = 26'h0; bus.rs_val = 32'h0; bus.pc_d = 32'h0;
    bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = 32'h0;
  endtask

  // One clock: compare every output against the model, then advance the model on the edge.
  task automatic cycle();
    logic exp_bd;
    logic exp_fl;
    #1;
    exp_bd = (bus.is_branch || bus.is_j || bus.is_jr) && !bus.exc_req && !reset;
    exp_fl = bus.eret && !bus.stall && !bus.exc_req && !reset;
    if (m_valid) begin
      chk("pc_f", bus.pc_f, m_pc);
      chk("adel_f", {31'd0, bus.adel_f}, {31'd0, ref_adel(m_pc)});
    end
    chk("bd_f", {31'd0, bus.bd_f}, {31'd0, exp_bd});
    chk("flush_fd", {31'd0, bus.flush_fd}, {31'd0, exp_fl});
    @(posedge clk);
    if (reset || m_valid) begin
      m_pc = ref_next(m_pc);
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_valid = 1'b0; m_pc = 32'h0;
    clear_ctrl();
    reset = 1'b1;
    bus.is_j = 1'b1;
    @(negedge clk);
    cycle();
    chk("rst_pc", bus.pc_f, 32'h0000_3000);
    cycle();
    reset = 1'b0;
    clear_ctrl();

    // Sequential fetch after reset.
    cycle();
    chk("t1_pc1", bus.pc_f, 32'h0000_3004);
    chk("t1_adel", {31'd0, bus.adel_f}, 32'd0);
    cycle();
    chk("t1_pc2", bus.pc_f, 32'h0000_3008);

    // Taken backward branch, then not taken.
    bus.is_branch = 1'b1; bus.pc_d = 32'h0000_3008; bus.imm16 = 16'hFFFE; bus.cmp_true = 1'b1;
    #1 chk("t2_bd", {31'd0, bus.bd_f}, 32'd1);
    cycle();
    chk("t2_taken", bus.pc_f, 32'h0000_3004);
    bus.cmp_true = 1'b0;
    cycle();
    chk("t2_nt", bus.pc_f, 32'h0000_3008);

    // Stalled taken branch: holds, then redirects once unstalled.
    bus.cmp_true = 1'b1; bus.pc_d = 32'h0000_3004; bus.imm16 = 16'h0010; bus.stall = 1'b1;
    cycle();
    chk("t3_hold1", bus.pc_f, 32'h0000_3008);
    chk("t3_bd", {31'd0, bus.bd_f}, 32'd1);
    cycle();
    chk("t3_hold2", bus.pc_f, 32'h0000_3008);
    bus.stall = 1'b0;
    cycle();
    chk("t3_tgt", bus.pc_f, 32'h0000_3048);

    // Exception overrides stall and jump.
    clear_ctrl();
    bus.exc_req = 1'b1; bus.stall = 1'b1; bus.is_j = 1'b1; bus.instr_index = 26'h0000C10;
    #1 chk("t4_bd", {31'd0, bus.bd_f}, 32'd0);
    cycle();
    chk("t4_pc", bus.pc_f, 32'h0000_4180);

    // Jump register targets and address errors.
    clear_ctrl();
    bus.is_jr = 1'b1; bus.rs_val = 32'h0000_3001;
    cycle();
    chk("t5_pc", bus.pc_f, 32'h0000_3001);
    chk("t5_adel1", {31'd0, bus.adel_f}, 32'd1);
    bus.rs_val = 32'h0000_7000;
    cycle();
    chk("t5_adel2", {31'd0, bus.adel_f}, 32'd1);
    bus.rs_val = 32'h0000_6ffc;
    cycle();
    chk("t5_adel3", {31'd0, bus.adel_f}, 32'd0);
    bus.rs_val = 32'hFFFF_FFFC;
    cycle();
    clear_ctrl();
    cycle();
    chk("wrap_pc", bus.pc_f, 32'h0000_0000);
    chk("wrap_adel", {31'd0, bus.adel_f}, 32'd1);

    // j target keeps the upper nibble of pc_d+4.
    bus.is_j = 1'b1; bus.pc_d = 32'h0FFF_FFFC; bus.instr_index = 26'h0000C04;
    cycle();
    chk("j_pc", bus.pc_f, 32'h1000_3010);

    // eret: flush and redirect; stalled eret holds.
    clear_ctrl();
    bus.eret = 1'b1; bus.epc = 32'h0000_3010;
    #1 chk("t6_flush", {31'd0, bus.flush_fd}, 32'd1);
    cycle();
    chk("t6_pc", bus.pc_f, 32'h0000_3010);
    bus.stall = 1'b1; bus.epc = 32'h0000_5000;
    #1 chk("t6_fl_stall", {31'd0, bus.flush_fd}, 32'd0);
    cycle();
    chk("t6_hold", bus.pc_f, 32'h0000_3010);

    // Reset discards a pending redirect.
    bus.stall = 1'b0; reset = 1'b1;
    cycle();
    chk("rst_mid", bus.pc_f, 32'h0000_3000);
    reset = 1'b0;
    clear_ctrl();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      clear_ctrl();
      reset         = ($urandom_range(0, 99) == 0);
      bus.exc_req   = ($urandom_range(0, 29) == 0);
      bus.stall     = ($urandom_range(0, 4) == 0);
      sel           = $urandom_range(0, 9);
      bus.eret      = (sel == 0) || ($urandom_range(0, 49) == 0);
      bus.is_jr     = (sel == 1);
      bus.is_j      = (sel == 2) || ($urandom_range(0, 49) == 0);
      bus.is_branch = (sel >= 3 && sel <= 5);
      bus.cmp_true  = $urandom_range(0, 1) == 1;
      bus.imm16     = 16'($urandom);
      bus.instr_index = 26'($urandom);
      bus.pc_d      = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0000_3000 + 32'($urandom_range(0, 16'h3fff)) * 32'd4;
      bus.rs_val    = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_2ff8 + 32'($urandom_range(0, 16'h1003)) * 32'd4;
      bus.epc       = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_3000 + 32'($urandom_range(0, 16'h0fff)) * 32'd4;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
